// File: rtl/lsf_pkg.sv
// Shared types and default sizes for the LSF r-bin histogram bank scheduler.
package lsf_pkg;

    localparam int LSF_RBINS    = 128;
    localparam int LSF_W_BIN    = 8;
    localparam int LSF_W_CNT    = 4;
    localparam int LSF_PIPE_LAT = 5;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        FILL,
        DRAIN,
        HOLD
    } hist_bank_state_t;

endpackage

// File: rtl/lsf_hist_bank_ctrl.sv
// Lifecycle controller for one histogram bank: clear sweep, fill, drain wait,
// result hold, plus the captured running maximum of the event.
module lsf_hist_bank_ctrl
    import lsf_pkg::*;
#(
    parameter int W_BIN      = LSF_W_BIN,
    parameter int W_CNT      = LSF_W_CNT,
    parameter int PIPE_LAT   = LSF_PIPE_LAT,
    parameter int CLR_CYCLES = LSF_RBINS + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             beat,
    input  logic             last,
    input  logic             take,
    input  logic [W_BIN-2:0] max_rbin,
    input  logic [W_CNT-1:0] max_count,
    input  logic             max_vld,
    output hist_bank_state_t state,
    output logic             enable,
    output logic             reset_rbins,
    output logic [W_BIN-2:0] best_rbin,
    output logic [W_CNT-1:0] best_count
);

    localparam int CW = $clog2((CLR_CYCLES > PIPE_LAT) ? CLR_CYCLES : PIPE_LAT);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(PIPE_LAT - 1);

    hist_bank_state_t state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [W_BIN-2:0] best_rbin_reg;
    logic [W_CNT-1:0] best_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_reg      <= CLEAR;
            cnt_reg        <= '0;
            best_rbin_reg  <= '0;
            best_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // The bank only raises vld on a strictly larger count, so the last latch is the max.
            if (state_reg == CLEAR) begin
                best_rbin_reg  <= '0;
                best_count_reg <= '0;
            end else if ((state_reg == FILL || state_reg == DRAIN) && max_vld) begin
                best_rbin_reg  <= max_rbin;
                best_count_reg <= max_count;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CLEAR: begin
                if (cnt_reg == CLR_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                if (beat) begin
                    state_next = last ? DRAIN : FILL;
                    cnt_next   = '0;
                end
            end
            FILL: begin
                if (beat && last) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end
            end
            DRAIN: begin
                if (cnt_reg == DRAIN_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (take) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign state       = state_reg;
    assign enable      = (state_reg == FILL) || (state_reg == DRAIN);
    assign reset_rbins = (state_reg == CLEAR);
    assign best_rbin   = best_rbin_reg;
    assign best_count  = best_count_reg;

endmodule

// File: rtl/lsf_hist_bank_scheduler.sv
// Ping-pong scheduler over two histogram banks: events alternate between banks,
// each bank's max is returned in claim order and the bank is then swept clear.
module lsf_hist_bank_scheduler
    import lsf_pkg::*;
#(
    parameter int RBINS      = LSF_RBINS,
    parameter int W_BIN      = LSF_W_BIN,
    parameter int W_CNT      = LSF_W_CNT,
    parameter int PIPE_LAT   = LSF_PIPE_LAT,
    parameter int CLR_CYCLES = RBINS + 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [W_BIN-1:0]       bin_tdata,
    input  logic                   bin_tvalid,
    input  logic                   bin_tlast,
    output logic                   bin_tready,
    output logic [2*W_BIN-1:0]     bank_bin_tdata,
    output logic [1:0]             bank_bin_tvalid,
    output logic [1:0]             bank_enable,
    output logic [1:0]             bank_reset_rbins,
    input  logic [2*(W_BIN-1)-1:0] bank_max_rbin,
    input  logic [2*W_CNT-1:0]     bank_max_count,
    input  logic [1:0]             bank_max_vld,
    output logic [W_BIN-2:0]       res_rbin,
    output logic [W_CNT-1:0]       res_count,
    output logic                   res_bank,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy
);

    hist_bank_state_t bank_state [2];
    logic [W_BIN-2:0] best_rbin  [2];
    logic [W_CNT-1:0] best_count [2];
    logic [W_BIN-1:0] fwd_data_reg  [2];
    logic             fwd_valid_reg [2];

    logic claim_ptr_reg;
    logic out_ptr_reg;
    logic accept;
    logic take_any;

    // Events are claimed strictly in alternation, so an open event always lives in bank claim_ptr.
    assign bin_tready = rst_n && !flush &&
                        ((bank_state[claim_ptr_reg] == IDLE) || (bank_state[claim_ptr_reg] == FILL));
    assign accept     = bin_tvalid && bin_tready;

    assign res_valid = rst_n && !flush && (bank_state[out_ptr_reg] == HOLD);
    assign take_any  = res_valid && res_ready;
    assign res_rbin  = best_rbin[out_ptr_reg];
    assign res_count = best_count[out_ptr_reg];
    assign res_bank  = out_ptr_reg;
    assign busy      = (bank_state[0] != IDLE) || (bank_state[1] != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            claim_ptr_reg <= 1'b0;
            out_ptr_reg   <= 1'b0;
        end else begin
            claim_ptr_reg <= claim_ptr_reg ^ (accept && bin_tlast);
            out_ptr_reg   <= out_ptr_reg ^ take_any;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic sel;
            assign sel = (claim_ptr_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    fwd_valid_reg[gi] <= 1'b0;
                    fwd_data_reg[gi]  <= '0;
                end else begin
                    fwd_valid_reg[gi] <= accept && sel;
                    fwd_data_reg[gi]  <= (accept && sel) ? bin_tdata : '0;
                end
            end

            assign bank_bin_tdata[gi*W_BIN +: W_BIN] = fwd_data_reg[gi];
            assign bank_bin_tvalid[gi]               = fwd_valid_reg[gi];

            lsf_hist_bank_ctrl #(
                .W_BIN      (W_BIN),
                .W_CNT      (W_CNT),
                .PIPE_LAT   (PIPE_LAT),
                .CLR_CYCLES (CLR_CYCLES)
            ) u_ctrl (
                .clk         (clk),
                .rst_n       (rst_n),
                .flush       (flush),
                .beat        (accept && sel),
                .last        (bin_tlast),
                .take        (take_any && (out_ptr_reg == 1'(gi))),
                .max_rbin    (bank_max_rbin[gi*(W_BIN-1) +: (W_BIN-1)]),
                .max_count   (bank_max_count[gi*W_CNT +: W_CNT]),
                .max_vld     (bank_max_vld[gi]),
                .state       (bank_state[gi]),
                .enable      (bank_enable[gi]),
                .reset_rbins (bank_reset_rbins[gi]),
                .best_rbin   (best_rbin[gi]),
                .best_count  (best_count[gi])
            );
        end
    endgenerate

endmodule
